// File: rtl/xrf_pkg.sv
// xrf_pkg: shared FSM state type and parameter defaults for the register file
package xrf_pkg;
  typedef enum logic {CLEAR, READY} state_t;
  localparam int XLEN_DEF = 64;
  localparam int NREGS_DEF = 32;
  localparam int BYPASS_DEF = 0;
endpackage

// File: rtl/xrf_if.sv
// xrf_if: write, mark and read-port bundle between a register file and its user
interface xrf_if import xrf_pkg::*; #(
  parameter int XLEN = XLEN_DEF,
  parameter int NREGS = NREGS_DEF
) ();
  localparam int AW = $clog2(NREGS);
  logic we_i;
  logic [AW-1:0] rd_i;
  logic [XLEN-1:0] d_i;
  logic [AW-1:0] rs1_i;
  logic [AW-1:0] rs2_i;
  logic [XLEN-1:0] q1_o;
  logic [XLEN-1:0] q2_o;
  logic mark_i;
  logic [AW-1:0] mrd_i;
  logic busy1_o;
  logic busy2_o;
  logic ready_o;
  modport master (
    output we_i, rd_i, d_i, rs1_i, rs2_i, mark_i, mrd_i,
    input q1_o, q2_o, busy1_o, busy2_o, ready_o
  );
  modport slave (
    input we_i, rd_i, d_i, rs1_i, rs2_i, mark_i, mrd_i,
    output q1_o, q2_o, busy1_o, busy2_o, ready_o
  );
endinterface

// File: rtl/xrf_sb.sv
// xrf_sb: pending-write scoreboard, one busy bit per register, set wins over clear
module xrf_sb import xrf_pkg::*; #(
  parameter int NREGS = NREGS_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic set_en,
  input  logic [$clog2(NREGS)-1:0] set_addr,
  input  logic clr_en,
  input  logic [$clog2(NREGS)-1:0] clr_addr,
  input  logic [$clog2(NREGS)-1:0] ra1,
  input  logic [$clog2(NREGS)-1:0] ra2,
  output logic b1,
  output logic b2
);
  localparam int AW = $clog2(NREGS);
  logic [NREGS-1:0] busy, nxt;
  // per-bit update: only the addressed bits can change, a mark beats a retiring write
  always_comb begin
    nxt = busy;
    for (int i = 0; i < NREGS; i++)
      nxt[i] = (set_en && set_addr == AW'(i)) || (busy[i] && !(clr_en && clr_addr == AW'(i)));
  end
  // busy bit register, cleared by reset
  always_ff @(posedge clk or posedge rst)
    if (rst) busy <= '0;
    else busy <= nxt;
  assign b1 = busy[ra1];
  assign b2 = busy[ra2];
endmodule

// File: rtl/xrf.sv
// xrf: 2-read/1-write register file with post-reset clear sequence and busy scoreboard
module xrf import xrf_pkg::*; #(
  parameter int XLEN = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int BYPASS = BYPASS_DEF
) (
  input logic clk_i,
  input logic reset_i,
  xrf_if.slave bus
);
  localparam int AW = $clog2(NREGS);
  logic [XLEN-1:0] mem [NREGS];
  state_t state, state_n;
  logic [AW-1:0] cnt, cnt_n, waddr;
  logic [XLEN-1:0] wdata;
  logic ready, wr, wen, b1, b2, byp1, byp2;
  assign ready = state == READY;
  assign wr = ready && bus.we_i;
  assign wen = !ready || (wr && bus.rd_i != '0);
  assign waddr = ready ? bus.rd_i : cnt;
  assign wdata = ready ? bus.d_i : '0;
  // FSM and clear-counter registers; reset restarts the clear from register 1
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      state <= CLEAR;
      cnt <= AW'(1);
    end else begin
      state <= state_n;
      cnt <= cnt_n;
    end
  // clear walks 1..NREGS-1, then the file becomes usable
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    if (state == CLEAR) begin
      state_n = cnt == AW'(NREGS - 1) ? READY : CLEAR;
      cnt_n = cnt == AW'(NREGS - 1) ? cnt : cnt + AW'(1);
    end
  end
  // storage has no reset so it maps onto distributed RAM; the clear sequence zeroes it
  always_ff @(posedge clk_i)
    if (wen) mem[waddr] <= wdata;
  assign byp1 = BYPASS != 0 && wr && bus.rs1_i == bus.rd_i;
  assign byp2 = BYPASS != 0 && wr && bus.rs2_i == bus.rd_i;
  assign bus.q1_o = !ready || bus.rs1_i == '0 ? '0 : byp1 ? bus.d_i : mem[bus.rs1_i];
  assign bus.q2_o = !ready || bus.rs2_i == '0 ? '0 : byp2 ? bus.d_i : mem[bus.rs2_i];
  xrf_sb #(.NREGS(NREGS)) u_sb (
    .clk(clk_i),
    .rst(reset_i),
    .set_en(ready && bus.mark_i && bus.mrd_i != '0),
    .set_addr(bus.mrd_i),
    .clr_en(wr),
    .clr_addr(bus.rd_i),
    .ra1(bus.rs1_i),
    .ra2(bus.rs2_i),
    .b1(b1),
    .b2(b2)
  );
  assign bus.busy1_o = ready && b1;
  assign bus.busy2_o = ready && b2;
  assign bus.ready_o = ready;
endmodule

// File: tb/tb_xrf.sv
// tb_xrf: directed checks of clear sequence, bypass, register 0, scoreboard and a small instance
module tb_xrf;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_vec = 0;
  int n_bad = 0;
  always #5 clk = ~clk;
  xrf_if #(.XLEN(64), .NREGS(32)) b0();
  xrf_if #(.XLEN(64), .NREGS(32)) b1();
  xrf_if #(.XLEN(32), .NREGS(16)) b2();
  assign b1.we_i = b0.we_i;
  assign b1.rd_i = b0.rd_i;
  assign b1.d_i = b0.d_i;
  assign b1.rs1_i = b0.rs1_i;
  assign b1.rs2_i = b0.rs2_i;
  assign b1.mark_i = b0.mark_i;
  assign b1.mrd_i = b0.mrd_i;
  xrf #(.XLEN(64), .NREGS(32), .BYPASS(0)) u0 (.clk_i(clk), .reset_i(rst), .bus(b0.slave));
  xrf #(.XLEN(64), .NREGS(32), .BYPASS(1)) u1 (.clk_i(clk), .reset_i(rst), .bus(b1.slave));
  xrf #(.XLEN(32), .NREGS(16), .BYPASS(0)) u2 (.clk_i(clk), .reset_i(rst), .bus(b2.slave));
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic put(input logic we, input logic [4:0] rd, input logic [63:0] d, input logic mk, input logic [4:0] mrd);
    b0.we_i = we;
    b0.rd_i = rd;
    b0.d_i = d;
    b0.mark_i = mk;
    b0.mrd_i = mrd;
    #1;
  endtask
  initial begin
    b0.rs1_i = '0;
    b0.rs2_i = '0;
    b2.we_i = 1'b0;
    b2.rd_i = '0;
    b2.d_i = '0;
    b2.rs1_i = '0;
    b2.rs2_i = '0;
    b2.mark_i = 1'b0;
    b2.mrd_i = '0;
    put(1'b0, 5'd0, 64'd0, 1'b0, 5'd0);
    chk("rst_ready", 64'(b0.ready_o), 64'd0);
    #10 rst = 1'b0;
    b0.rs1_i = 5'd3;
    b0.rs2_i = 5'd3;
    put(1'b1, 5'd3, '1, 1'b1, 5'd3);
    repeat (10) tick;
    chk("clr_ready", 64'(b0.ready_o), 64'd0);
    chk("clr_q1", b0.q1_o, 64'd0);
    chk("clr_q2", b0.q2_o, 64'd0);
    chk("clr_busy1", 64'(b0.busy1_o), 64'd0);
    rst = 1'b1;
    #2;
    chk("midrst_ready", 64'(b0.ready_o), 64'd0);
    rst = 1'b0;
    for (int i = 1; i <= 31; i++) begin
      tick;
      chk($sformatf("rdy_edge%0d", i), 64'(b0.ready_o), 64'(i == 31));
    end
    put(1'b0, 5'd0, 64'd0, 1'b0, 5'd0);
    chk("u2_ready", 64'(b2.ready_o), 64'd1);
    for (int r = 0; r < 32; r++) begin
      b0.rs1_i = 5'(r);
      b0.rs2_i = 5'(r);
      #1;
      chk($sformatf("zero_q1_r%0d", r), b0.q1_o, 64'd0);
      chk($sformatf("zero_q2_r%0d", r), b0.q2_o, 64'd0);
      if (r == 3) chk("clr_mark_ignored", 64'(b0.busy1_o), 64'd0);
    end
    b0.rs1_i = 5'd5;
    b0.rs2_i = 5'd5;
    put(1'b1, 5'd5, 64'hDEADBEEFFEEDFACE, 1'b0, 5'd0);
    chk("nobyp_old_q1", b0.q1_o, 64'd0);
    chk("nobyp_old_q2", b0.q2_o, 64'd0);
    chk("byp_q1", b1.q1_o, 64'hDEADBEEFFEEDFACE);
    chk("byp_q2", b1.q2_o, 64'hDEADBEEFFEEDFACE);
    tick;
    put(1'b0, 5'd0, 64'd0, 1'b0, 5'd0);
    chk("nobyp_new_q1", b0.q1_o, 64'hDEADBEEFFEEDFACE);
    chk("nobyp_new_q2", b0.q2_o, 64'hDEADBEEFFEEDFACE);
    chk("byp_stored_q1", b1.q1_o, 64'hDEADBEEFFEEDFACE);
    b0.rs1_i = 5'd0;
    b0.rs2_i = 5'd5;
    put(1'b0, 5'd0, 64'd0, 1'b1, 5'd5);
    chk("mark5_pre", 64'(b0.busy2_o), 64'd0);
    tick;
    put(1'b1, 5'd0, '1, 1'b0, 5'd0);
    chk("r0_wr_q1", b0.q1_o, 64'd0);
    chk("r0_byp_q1", b1.q1_o, 64'd0);
    chk("r0_wr_busy5_pre", 64'(b0.busy2_o), 64'd1);
    tick;
    put(1'b0, 5'd0, 64'd0, 1'b0, 5'd0);
    chk("r0_after_q1", b0.q1_o, 64'd0);
    chk("r0_after_busy5", 64'(b0.busy2_o), 64'd1);
    chk("r0_after_busy0", 64'(b0.busy1_o), 64'd0);
    put(1'b1, 5'd5, 64'h1234, 1'b0, 5'd0);
    tick;
    put(1'b0, 5'd0, 64'd0, 1'b0, 5'd0);
    chk("wr5_busy_clr", 64'(b0.busy2_o), 64'd0);
    chk("wr5_q2", b0.q2_o, 64'h1234);
    b0.rs1_i = 5'd7;
    b0.rs2_i = 5'd9;
    put(1'b0, 5'd0, 64'd0, 1'b1, 5'd7);
    chk("mark7_pre", 64'(b0.busy1_o), 64'd0);
    tick;
    put(1'b1, 5'd7, 64'h77, 1'b0, 5'd0);
    chk("mark7_set", 64'(b0.busy1_o), 64'd1);
    tick;
    put(1'b1, 5'd9, 64'h99, 1'b1, 5'd9);
    chk("wr7_busy_clr", 64'(b0.busy1_o), 64'd0);
    chk("mw9_pre", 64'(b0.busy2_o), 64'd0);
    tick;
    put(1'b0, 5'd0, 64'd0, 1'b0, 5'd0);
    chk("mw9_mark_wins", 64'(b0.busy2_o), 64'd1);
    chk("mw9_r7_untouched", 64'(b0.busy1_o), 64'd0);
    chk("wr7_q1", b0.q1_o, 64'h77);
    chk("wr9_q2", b0.q2_o, 64'h99);
    tick;
    chk("mw9_persist", 64'(b0.busy2_o), 64'd1);
    b0.rs1_i = 5'd0;
    put(1'b0, 5'd0, 64'd0, 1'b1, 5'd0);
    tick;
    put(1'b0, 5'd0, 64'd0, 1'b0, 5'd0);
    chk("mark0_ignored", 64'(b0.busy1_o), 64'd0);
    for (int r = 1; r < 16; r++) begin
      b2.we_i = 1'b1;
      b2.rd_i = 4'(r);
      b2.d_i = 32'(r) * 32'h11111111 ^ 32'hA5000000;
      tick;
    end
    b2.we_i = 1'b0;
    for (int r = 0; r < 16; r++) begin
      b2.rs1_i = 4'(r);
      b2.rs2_i = 4'(15 - r);
      #1;
      chk($sformatf("u2_q1_r%0d", r), 64'(b2.q1_o), r == 0 ? 64'd0 : 64'(32'(r) * 32'h11111111 ^ 32'hA5000000));
      chk($sformatf("u2_q2_r%0d", 15 - r), 64'(b2.q2_o), r == 15 ? 64'd0 : 64'(32'(15 - r) * 32'h11111111 ^ 32'hA5000000));
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
